fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset, sampled on rising clk.
REQ-004 stop  input  1  stall from the IF/ID register; same meaning as the IF/ID stop.
REQ-005 branch_taken  input  1  redirect request from a later stage.
REQ-006 branch_target  input  8  redirect address, valid with branch_taken.
REQ-007 instr_mem_addr  output  8  instruction memory read address, driven from the PC register.
REQ-008 instr_mem_rdata  input  12  memory data for the address presented on the previous cycle (1-cycle synchronous read).
REQ-009 instruction_out  output  12  instruction to the IF/ID instruction_in.
REQ-010 pc_out  output  8  address of the instruction on instruction_out.
REQ-011 fetch_valid  output  1  instruction_out holds a real fetched instruction, not a bubble.
REQ-012 halted  output  1  fetch stopped by a HALT instruction.

Function
REQ-013 States SHALL be FILL (memory read in flight, no valid data), RUN (data valid) and HALT (fetch stopped).
REQ-014 instr_mem_addr SHALL equal pc_q at all times; pc_q SHALL be 8 bits and increment modulo 256 (8'hFF+1 = 8'h00).
REQ-015 In FILL and HALT, instruction_out SHALL be NOP (12'h000) and fetch_valid SHALL be 0.
REQ-016 In RUN, instruction_out SHALL equal instr_mem_rdata combinationally, fetch_valid SHALL be 1, and pc_out SHALL equal addr_q (the address whose read is returning).
REQ-017 Update priority each cycle SHALL be: reset > stop > branch_taken > HALT detect > sequential advance.
REQ-018 While stop=1, pc_q, addr_q and state SHALL hold, so the same address is re-read and instruction_out is unchanged.
REQ-019 Sequential advance SHALL load addr_q <= pc_q and pc_q <= pc_q+1; FILL SHALL go to RUN, and RUN SHALL stay in RUN.
REQ-020 branch_taken=1 with stop=0 in any state SHALL load pc_q <= branch_target and enter FILL, so exactly one NOP bubble follows.
REQ-021 branch_taken SHALL override a HALT decoded in the same cycle, because the branch belongs to an older instruction.
REQ-022 In HALT, pc_q and addr_q SHALL hold and halted SHALL be 1; only reset or branch_taken leaves HALT.
REQ-023 The sources of branch_taken asserted during stop SHALL hold it until stop deasserts; fetch_unit SHALL NOT latch it.

Reset
REQ-024 Reset SHALL set: pc_q=8'h00, addr_q=8'h00, state=FILL, instruction_out=12'h000, pc_out=8'h00, fetch_valid=0, halted=0.
REQ-025 Reset mid-operation, including during stop, branch or HALT, SHALL override everything on that edge.
REQ-026 The first valid instruction SHALL be address 0, appearing on the second edge after reset deasserts.

Configuration
REQ-027 With FETCH_HALT_DETECT_EN defined: in RUN with stop=0 and branch_taken=0, instr_mem_rdata[11:8]==4'hF SHALL enter HALT.
REQ-028 In that case the HALT word SHALL itself be presented for that one cycle with fetch_valid=1, and pc_q SHALL NOT advance.
REQ-029 Without FETCH_HALT_DETECT_EN: there SHALL be no HALT state logic, halted SHALL be tied to 0, and opcode 4'hF SHALL be fetched as an ordinary instruction.

Structure
REQ-030 The shared package cpu_pkg SHALL hold INSTR_W=12, PC_W=8, NOP_INSTR=12'h000, OPC_HALT=4'hF and the fetch_state_t enum {FILL, RUN, HALT}.
REQ-031 One sub-module, fetch_pc_reg, SHALL hold pc_q with hold, load and increment controls.

Verification
REQ-032 Reset 2 cycles, memory word = 12'h100+addr -> cycle 1 NOP/fetch_valid=0, then 12'h100, 12'h101, 12'h102 with pc_out 0,1,2.
REQ-033 stop=1 for 3 cycles while showing addr 5 -> instruction_out=12'h105 and pc_out=5 held; after release 12'h106 next cycle.
REQ-034 branch_taken=1, target 8'h40, while showing addr 3 -> one NOP (fetch_valid=0), then 12'h140, 12'h141.
REQ-035 PC at 8'hFE running -> pc_out sequence FE, FF, 00 with no bubble.
REQ-036 FETCH_HALT_DETECT_EN, memory[7]=12'hF00 -> 12'hF00 shown once, then halted=1, NOP, pc_q frozen; then branch to 8'h10 -> FILL, then 12'h110.
REQ-037 Same cycle as HALT word: stop=1 -> hold with no halt entry; branch_taken=1 -> redirect wins, halted stays 0; reset during HALT -> all reset values next edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants and fetch-stage types; used by fetch_unit and fetch_pc_reg.
// No logic, so no latency. No flow control.
package cpu_pkg;

    localparam int INSTR_W = 12;
    localparam int PC_W    = 8;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 12'h000;
    localparam logic [3:0]         OPC_HALT  = 4'hF;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    function automatic logic is_halt_opcode(input logic [INSTR_W-1:0] instr);
        return instr[INSTR_W-1 -: 4] == OPC_HALT;
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with hold > load > increment priority; wraps modulo 2^PC_W.
// Next PC is visible one cycle after the controls. hold_i freezes the PC.
module fetch_pc_reg
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            hold_i,
    input  logic            load_i,
    input  logic            inc_i,
    input  logic [PC_W-1:0] load_val_i,
    output logic [PC_W-1:0] pc_o
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (hold_i) begin
            pc_d = pc_q;
        end else if (load_i) begin
            pc_d = load_val_i;
        end else if (inc_i) begin
            pc_d = pc_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: 1-cycle synchronous memory, one NOP bubble after reset/branch.
// stop freezes the stage; optional HALT opcode detection under FETCH_HALT_DETECT_EN.
module fetch_unit
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               stop,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    output logic [PC_W-1:0]    instr_mem_addr,
    input  logic [INSTR_W-1:0] instr_mem_rdata,
    output logic [INSTR_W-1:0] instruction_out,
    output logic [PC_W-1:0]    pc_out,
    output logic               fetch_valid,
    output logic               halted
);

    fetch_state_t       state_q;
    logic [PC_W-1:0]    pc_q;
    logic [PC_W-1:0]    addr_q;
    logic               stalled_q;
    logic [INSTR_W-1:0] hold_instr_q;
    logic [INSTR_W-1:0] cur_instr;
    logic               in_halt;
    logic               halt_hit;
    logic               pc_hold;
    logic               pc_load;
    logic               pc_inc;

    // The PC keeps presenting the next address during a stall, so the memory
    // returns the following word; replay the word captured when the stall began.
    assign cur_instr = stalled_q ? hold_instr_q : instr_mem_rdata;

`ifdef FETCH_HALT_DETECT_EN
    assign in_halt  = (state_q == HALT);
    assign halt_hit = (state_q == RUN) && is_halt_opcode(cur_instr);
`else
    assign in_halt  = 1'b0;
    assign halt_hit = 1'b0;
`endif

    assign pc_load = !stop && branch_taken;
    assign pc_hold = stop || (!branch_taken && (halt_hit || in_halt));
    assign pc_inc  = !pc_hold && !pc_load;

    fetch_pc_reg u_pc_reg (
        .clk        (clk),
        .reset      (reset),
        .hold_i     (pc_hold),
        .load_i     (pc_load),
        .inc_i      (pc_inc),
        .load_val_i (branch_target),
        .pc_o       (pc_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= FILL;
            addr_q       <= '0;
            stalled_q    <= 1'b0;
            hold_instr_q <= NOP_INSTR;
        end else begin
            stalled_q <= stop;
            if (stop && !stalled_q) begin
                hold_instr_q <= cur_instr;
            end
            if (!stop) begin
                if (branch_taken) begin
                    state_q <= FILL;
`ifdef FETCH_HALT_DETECT_EN
                end else if (halt_hit || in_halt) begin
                    state_q <= HALT;
`endif
                end else begin
                    addr_q  <= pc_q;
                    state_q <= RUN;
                end
            end
        end
    end

    assign instr_mem_addr  = pc_q;
    assign fetch_valid     = (state_q == RUN);
    assign instruction_out = fetch_valid ? cur_instr : NOP_INSTR;
    assign pc_out          = addr_q;
    assign halted          = in_halt;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized stop/branch/reset
// against a stream-level reference model of the fetch sequence.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stop;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic [7:0]  instr_mem_addr;
    logic [11:0] instr_mem_rdata = 12'h000;
    logic [11:0] instruction_out;
    logic [7:0]  pc_out;
    logic        fetch_valid;
    logic        halted;

`ifdef FETCH_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    logic [11:0] mem [256];
    always @(posedge clk) instr_mem_rdata <= mem[instr_mem_addr];

    fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .stop            (stop),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .instr_mem_addr  (instr_mem_addr),
        .instr_mem_rdata (instr_mem_rdata),
        .instruction_out (instruction_out),
        .pc_out          (pc_out),
        .fetch_valid     (fetch_valid),
        .halted          (halted)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: which address is on display, which comes next, halted flag.
    bit         m_valid;
    bit         m_halted;
    logic [7:0] m_show;
    logic [7:0] m_next;

    task automatic model_edge(input bit r, input bit s, input bit b, input logic [7:0] t);
        logic [11:0] w;
        w = mem[m_show];
        if (r) begin
            m_valid = 0; m_halted = 0; m_show = 8'h00; m_next = 8'h00;
        end else if (s) begin
            // frozen
        end else if (b) begin
            m_valid = 0; m_halted = 0; m_next = t;
        end else if (m_halted) begin
            // frozen until branch or reset
        end else if (HALT_EN && m_valid && w[11:8] == 4'hF) begin
            m_valid = 0; m_halted = 1;
        end else begin
            m_valid = 1; m_show = m_next; m_next = m_next + 8'd1;
        end
    endtask

    task automatic compare_all();
        check("fetch_valid", fetch_valid, m_valid);
        check("instruction_out", instruction_out, m_valid ? mem[m_show] : 12'h000);
        if (m_valid) check("pc_out", pc_out, m_show);
        check("halted", halted, m_halted);
        check("instr_mem_addr", instr_mem_addr, m_next);
    endtask

    task automatic step(input bit r, input bit s, input bit b, input logic [7:0] t);
        reset = r; stop = s; branch_taken = b; branch_target = t;
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_edge(r, s, b, t);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"}, fetch_valid, 1'b0);
        check({tag, "_instr"}, instruction_out, 12'h000);
        check({tag, "_pc_out"}, pc_out, 8'h00);
        check({tag, "_halted"}, halted, 1'b0);
        check({tag, "_addr"}, instr_mem_addr, 8'h00);
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 12'h100 + 12'(a);
        mem[7] = 12'hF00;
        for (int i = 0; i < 6; i++) mem[$urandom_range(8'hEF, 8'h80)] = {4'hF, 8'($urandom)};

        reset = 1; stop = 0; branch_taken = 0; branch_target = 8'h00;
        @(posedge clk);
        model_edge(1, 0, 0, 8'h00);
        #1;
        step(1, 0, 0, 8'h00);
        check_reset_values("reset");

        // First fetch stream after reset
        step(0, 0, 0, 8'h00);
        check("first_instr", instruction_out, 12'h100);
        check("first_pc", pc_out, 8'h00);
        step(0, 0, 0, 8'h00);
        check("second_instr", instruction_out, 12'h101);
        step(0, 0, 0, 8'h00);
        check("third_pc", pc_out, 8'h02);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h00);

        // Stall while showing address 5
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 8'h00);
            check("stall_instr", instruction_out, 12'h105);
            check("stall_pc", pc_out, 8'h05);
        end
        step(0, 0, 0, 8'h00);
        check("after_stall", instruction_out, 12'h106);

        // Branch: exactly one bubble
        step(0, 0, 1, 8'h40);
        check("branch_bubble", fetch_valid, 1'b0);
        step(0, 0, 0, 8'h00);
        check("branch_tgt0", instruction_out, 12'h140);
        step(0, 0, 0, 8'h00);
        check("branch_tgt1", instruction_out, 12'h141);

        // PC wrap
        step(0, 0, 1, 8'hFE);
        step(0, 0, 0, 8'h00);
        check("wrap_fe", pc_out, 8'hFE);
        step(0, 0, 0, 8'h00);
        check("wrap_ff", pc_out, 8'hFF);
        step(0, 0, 0, 8'h00);
        check("wrap_00", pc_out, 8'h00);
        check("wrap_valid", fetch_valid, 1'b1);

        // HALT word at address 7
        step(0, 0, 1, 8'h06);
        step(0, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        check("halt_word", instruction_out, 12'hF00);
        check("halt_word_valid", fetch_valid, 1'b1);
        step(0, 0, 0, 8'h00);
`ifdef FETCH_HALT_DETECT_EN
        check("halt_entered", halted, 1'b1);
        check("halt_nop", instruction_out, 12'h000);
        step(0, 0, 0, 8'h00);
        check("halt_pc_frozen", instr_mem_addr, 8'h08);
`else
        check("halt_ordinary", instruction_out, 12'h108);
`endif
        step(0, 0, 1, 8'h10);
        check("halt_exit_fill", fetch_valid, 1'b0);
        step(0, 0, 0, 8'h00);
        check("halt_exit_instr", instruction_out, 12'h110);

        // stop and branch in the same cycle as the HALT word
        step(0, 0, 1, 8'h07);
        step(0, 0, 0, 8'h00);
        step(0, 1, 0, 8'h00);
        check("halt_stop_hold", instruction_out, 12'hF00);
        check("halt_stop_nohalt", halted, 1'b0);
        step(0, 0, 1, 8'h20);
        check("halt_branch_wins", halted, 1'b0);
        step(0, 0, 0, 8'h00);
        check("halt_branch_instr", instruction_out, 12'h120);

        // Reset while halted (or while running, without detection)
        step(0, 0, 1, 8'h07);
        step(0, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        step(1, 0, 0, 8'h00);
        check_reset_values("reset_in_halt");

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(99, 0) < 2,
                 $urandom_range(99, 0) < 25,
                 $urandom_range(99, 0) < 12,
                 8'($urandom));
        end
        step(0, 0, 0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
